// File: rtl/vga_text_renderer.sv
// vga_text_renderer: 80x60 text-mode pixel pipeline with font lookup and blinking block cursor
// Five-stage pipeline: address, RAM read, font address, ROM read, colour; sync/blank ride alongside.
module vga_text_renderer #(
    parameter int HORIZ_PIXELS = 640,
    parameter int VERT_PIXELS = 480,
    parameter int COLS = 80,
    parameter int ROWS = 60,
    parameter logic [7:0] FG_COLOR = 8'hFF,
    parameter logic [7:0] BG_COLOR = 8'h00,
    parameter int BLINK_BITS = 5
) (
    input  logic pixel_clk,
    input  logic reset,
    input  logic hsync_in,
    input  logic vsync_in,
    input  logic blank_in,
    input  logic [$clog2(HORIZ_PIXELS)-1:0] x,
    input  logic [$clog2(VERT_PIXELS)-1:0] y,
    input  logic cursor_en,
    input  logic [6:0] cursor_col,
    input  logic [5:0] cursor_row,
    output logic [$clog2(COLS*ROWS)-1:0] char_addr,
    input  logic [7:0] char_data,
    output logic [10:0] font_addr,
    input  logic [7:0] font_data,
    output logic hsync_out,
    output logic vsync_out,
    output logic [7:0] rgb
);
    localparam int XW = $clog2(HORIZ_PIXELS);
    localparam int YW = $clog2(VERT_PIXELS);
    localparam int AW = $clog2(COLS*ROWS);
    logic [4:0] hs_sr, vs_sr;
    logic [3:0] bl_sr, hit_sr;
    logic [3:0][2:0] xl_sr;
    logic [1:0][2:0] yl_sr;
    logic vs_q;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic hit, pix;
    assign hit = cursor_en && (x[XW-1:3] == cursor_col) && (y[YW-1:3] == cursor_row);
    // Glyph bit 7 is the leftmost pixel; the cursor inverts it during the on-phase.
    assign pix = font_data[3'd7 - xl_sr[3]] ^ (hit_sr[3] & blink_cnt[BLINK_BITS-1]);
    assign hsync_out = hs_sr[4];
    assign vsync_out = vs_sr[4];
    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            char_addr <= '0;
            font_addr <= '0;
            rgb <= '0;
            hs_sr <= '1;
            vs_sr <= '1;
            bl_sr <= '1;
            hit_sr <= '0;
            xl_sr <= '0;
            yl_sr <= '0;
            vs_q <= 1'b1;
            blink_cnt <= '0;
        end else begin
            char_addr <= AW'(32'(y[YW-1:3]) * COLS + 32'(x[XW-1:3]));
            font_addr <= {char_data, yl_sr[1]};
            hs_sr <= {hs_sr[3:0], hsync_in};
            vs_sr <= {vs_sr[3:0], vsync_in};
            bl_sr <= {bl_sr[2:0], blank_in};
            hit_sr <= {hit_sr[2:0], hit};
            xl_sr <= {xl_sr[2:0], x[2:0]};
            yl_sr <= {yl_sr[0], y[2:0]};
            vs_q <= vsync_in;
            if (vs_q && !vsync_in) blink_cnt <= blink_cnt + BLINK_BITS'(1);
            rgb <= bl_sr[3] ? 8'h00 : (pix ? FG_COLOR : BG_COLOR);
        end
    end
endmodule

// File: tb/tb_vga_text_renderer.sv
// tb_vga_text_renderer: vector table, corner sequences and random stimulus against a per-pixel model
module tb_vga_text_renderer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic hsync_in = 1'b1, vsync_in = 1'b1, blank_in = 1'b1;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic cursor_en = 1'b0;
    logic [6:0] cursor_col = '0;
    logic [5:0] cursor_row = '0;
    logic [12:0] char_addr;
    logic [7:0] char_data;
    logic [10:0] font_addr;
    logic [7:0] font_data;
    logic hsync_out, vsync_out;
    logic [7:0] rgb;

    always #5 clk = ~clk;

    vga_text_renderer dut (
        .pixel_clk(clk), .reset(reset), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .blank_in(blank_in), .x(x), .y(y), .cursor_en(cursor_en), .cursor_col(cursor_col),
        .cursor_row(cursor_row), .char_addr(char_addr), .char_data(char_data),
        .font_addr(font_addr), .font_data(font_data), .hsync_out(hsync_out),
        .vsync_out(vsync_out), .rgb(rgb)
    );

    logic [7:0] text_ram [8192];
    logic [7:0] font_rom [2048];
    always @(posedge clk) begin
        char_data <= text_ram[char_addr];
        font_data <= font_rom[font_addr];
    end

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic bl, hs, vs, cen;
        logic [6:0] cc;
        logic [5:0] cr;
        logic fix;
        logic [7:0] frgb;
    } smp_t;

    typedef struct {
        logic [9:0] x;
        logic [8:0] y;
        logic bl, cen;
        logic [6:0] cc;
        logic [5:0] cr;
        logic [7:0] exp_rgb;
    } vec_t;

    smp_t hist [4096];
    int ec [4096];
    int n = 0, checks = 0, errors = 0, low_cnt = 0, first_low = -1;
    logic fix_next = 1'b0;
    logic [7:0] fix_val = '0;

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s cycle %0d got %0h expected %0h", nm, n, got, exp);
        end
    endtask

    function automatic int cell_of(input smp_t s);
        return (int'(s.y) / 8) * 80 + int'(s.x) / 8;
    endfunction

    // Pixel colour straight from the screen rules: look up the character, its glyph row, the pixel bit.
    function automatic int model_rgb(input smp_t s, input int edges);
        logic [7:0] g;
        logic pix, hit, phase;
        if (s.bl) return 0;
        g = font_rom[int'(text_ram[cell_of(s)]) * 8 + int'(s.y) % 8];
        pix = g[7 - int'(s.x) % 8];
        hit = s.cen && (int'(s.x) / 8 == int'(s.cc)) && (int'(s.y) / 8 == int'(s.cr));
        phase = (edges % 32) >= 16;
        return (pix ^ (hit && phase)) ? 8'hFF : 8'h00;
    endfunction

    task automatic step();
        smp_t s;
        int k;
        s.x = x; s.y = y; s.bl = blank_in; s.hs = hsync_in; s.vs = vsync_in;
        s.cen = cursor_en; s.cc = cursor_col; s.cr = cursor_row; s.fix = fix_next; s.frgb = fix_val;
        hist[n] = s;
        fix_next = 1'b0;
        ec[n] = (n == 0 ? 0 : ec[n-1]) + (((n == 0 || hist[n-1].vs) && !vsync_in) ? 1 : 0);
        @(posedge clk);
        #1;
        chk("char_addr", char_addr, cell_of(s));
        if (n >= 2) begin
            k = n - 2;
            chk("font_addr", font_addr, int'(text_ram[cell_of(hist[k])]) * 8 + int'(hist[k].y) % 8);
        end
        if (n >= 4) begin
            k = n - 4;
            chk("rgb", rgb, model_rgb(hist[k], ec[n-1]));
            chk("hsync_out", hsync_out, hist[k].hs);
            chk("vsync_out", vsync_out, hist[k].vs);
            if (hist[k].fix) chk("rgb_vec", rgb, hist[k].frgb);
        end else begin
            chk("rgb_refill", rgb, 0);
            chk("hsync_refill", hsync_out, 1);
            chk("vsync_refill", vsync_out, 1);
        end
        if (!hsync_out) begin
            if (low_cnt == 0) first_low = n;
            low_cnt++;
        end
        n++;
    endtask

    task automatic pixel(input int px, input int py, input logic bl, input logic fx, input logic [7:0] fv);
        x = 10'(px); y = 9'(py); blank_in = bl; fix_next = fx; fix_val = fv;
        step();
    endtask

    task automatic vsync_edges(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            blank_in = 1'b1;
            vsync_in = 1'b0;
            step();
            vsync_in = 1'b1;
            step();
        end
    endtask

    vec_t vt [10];
    int start;

    initial begin
        for (int i = 0; i < 8192; i++) text_ram[i] = 8'($urandom);
        for (int i = 0; i < 2048; i++) font_rom[i] = 8'($urandom);
        text_ram[0] = 8'h41;
        text_ram[4799] = 8'h41;
        text_ram[163] = 8'h20;
        text_ram[164] = 8'h20;
        text_ram[165] = 8'h7F;
        font_rom[8'h41 * 8] = 8'h18;
        for (int r = 0; r < 8; r++) begin
            font_rom[8'h20 * 8 + r] = 8'h00;
            font_rom[8'h7F * 8 + r] = 8'hFF;
        end
        for (int i = 0; i < 8; i++) vt[i] = '{10'(i), 9'd0, 1'b0, 1'b0, 7'd0, 6'd0, 8'h00};
        vt[3].exp_rgb = 8'hFF;
        vt[4].exp_rgb = 8'hFF;
        vt[8] = '{10'd41, 9'd17, 1'b0, 1'b0, 7'd0, 6'd0, 8'hFF};
        vt[9] = '{10'd26, 9'd18, 1'b0, 1'b0, 7'd0, 6'd0, 8'h00};

        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;

        for (int i = 0; i < 10; i++) begin
            cursor_en = vt[i].cen; cursor_col = vt[i].cc; cursor_row = vt[i].cr;
            pixel(int'(vt[i].x), int'(vt[i].y), vt[i].bl, 1'b1, vt[i].exp_rgb);
        end
        for (int i = 0; i < 5; i++) pixel(0, 0, 1'b1, 1'b0, 8'h00);

        pixel(639, 479, 1'b0, 1'b0, 8'h00);
        chk("char_addr_max", char_addr, 4799);
        pixel(0, 0, 1'b0, 1'b0, 8'h00);
        pixel(0, 0, 1'b0, 1'b0, 8'h00);
        chk("font_addr_max", font_addr, 11'h20F);

        cursor_en = 1'b1; cursor_col = 7'd3; cursor_row = 6'd2;
        vsync_edges(16);
        pixel(24, 16, 1'b0, 1'b1, 8'hFF);
        pixel(31, 16, 1'b0, 1'b1, 8'hFF);
        pixel(32, 16, 1'b0, 1'b1, 8'h00);
        pixel(25, 17, 1'b1, 1'b1, 8'h00);
        pixel(41, 17, 1'b1, 1'b1, 8'h00);
        for (int i = 0; i < 5; i++) pixel(0, 0, 1'b1, 1'b0, 8'h00);
        vsync_edges(16);
        pixel(24, 16, 1'b0, 1'b1, 8'h00);
        pixel(41, 17, 1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 5; i++) pixel(0, 0, 1'b1, 1'b0, 8'h00);

        cursor_en = 1'b0;
        low_cnt = 0;
        first_low = -1;
        start = n + 10;
        for (int i = 0; i < 130; i++) begin
            hsync_in = (i >= 10 && i < 106) ? 1'b0 : 1'b1;
            pixel(int'($urandom_range(0, 639)), int'($urandom_range(0, 479)), 1'($urandom_range(0, 1)), 1'b0, 8'h00);
        end
        chk("hs_low_len", low_cnt, 96);
        chk("hs_first_low", first_low, start + 4);

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                cursor_col = 7'($urandom_range(0, 79));
                cursor_row = 6'($urandom_range(0, 59));
                cursor_en = $urandom_range(0, 3) != 0;
            end
            if ($urandom_range(0, 2) == 0) begin
                x = {cursor_col, 3'($urandom_range(0, 7))};
                y = {cursor_row, 3'($urandom_range(0, 7))};
            end else begin
                x = 10'($urandom_range(0, 639));
                y = 9'($urandom_range(0, 479));
            end
            blank_in = $urandom_range(0, 4) == 0;
            if ($urandom_range(0, 19) == 0) hsync_in = ~hsync_in;
            if ($urandom_range(0, 7) == 0) vsync_in = ~vsync_in;
            step();
        end

        #2;
        reset = 1'b1;
        #1;
        chk("rst_rgb", rgb, 0);
        chk("rst_hsync", hsync_out, 1);
        chk("rst_vsync", vsync_out, 1);
        chk("rst_char_addr", char_addr, 0);
        chk("rst_font_addr", font_addr, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 300; i++) begin
            x = 10'($urandom_range(0, 639));
            y = 9'($urandom_range(0, 479));
            blank_in = $urandom_range(0, 4) == 0;
            cursor_en = 1'b1;
            if ($urandom_range(0, 19) == 0) hsync_in = ~hsync_in;
            if ($urandom_range(0, 3) == 0) vsync_in = ~vsync_in;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
